// File: rtl/stage_sample_output_pkg.sv
// rtl/stage_sample_output_pkg.sv - shared widths and sample type for the sample output stage
// Purpose: sample and I2S slot widths used by stage_sample_output and sample_fifo.
// Ports: none (package).
package stage_sample_output_pkg;

    localparam int SAMPLE_WIDTH  = 16;
    localparam int I2S_SLOT_BITS = 16;
    // Left and right slots together make one I2S frame word.
    localparam int FRAME_BITS    = 2 * I2S_SLOT_BITS;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/stage_sample_output_fifo.sv
// rtl/stage_sample_output_fifo.sv - synchronous sample FIFO with registered level
// Purpose: small power-of-two FIFO between sample completion and I2S frame timing.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and sample
//   pop             read request (ignored when empty)
//   head_data       sample at the FIFO head
//   level           registered occupancy
//   full, empty     pointer-derived status
module sample_fifo
    import stage_sample_output_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [SAMPLE_WIDTH-1:0]   push_data,
    input  logic                      pop,
    output logic [SAMPLE_WIDTH-1:0]   head_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] level_q, level_d;
    sample_t        mem_q [DEPTH];
    sample_t        mem_d [DEPTH];
    logic           do_pop;
    logic           do_push;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                       (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    // Pop is evaluated first, so a full FIFO that is popping accepts the push.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign level     = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + PTR_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/stage_sample_output.sv
// rtl/stage_sample_output.sv - buffers mono samples and serializes them as I2S
// Purpose: FIFO-buffered mono sample to I2S (16 bits per slot, same sample on
//   left and right), BCLK/LRCLK generated from i_Clock.
// Optional feature: define SAMPLE_OUTPUT_UNDERRUN_COUNT_EN to add o_UnderrunCount.
// Ports:
//   i_Clock, i_Reset_n     clock, asynchronous active-low reset
//   i_SampleReady/i_Sample one-cycle strobe with a completed signed sample
//   i_ClearFlags           clears o_Overflow (and the underrun counter)
//   o_FifoLevel            occupied FIFO slots
//   o_Overflow             sticky, a sample was dropped
//   o_Underrun             one-cycle pulse, frame started with the FIFO empty
//   o_BitClock, o_LRClock, o_SerialData  I2S BCLK, WS (0 = left), SD
//   o_UnderrunCount        saturating underrun counter (optional)
module stage_sample_output
    import stage_sample_output_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 2
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_SampleReady,
    input  logic [SAMPLE_WIDTH-1:0]       i_Sample,
    input  logic                          i_ClearFlags,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
    output logic                          o_Overflow,
    output logic                          o_Underrun,
    output logic                          o_BitClock,
    output logic                          o_LRClock,
    output logic                          o_SerialData
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]                   o_UnderrunCount
`endif
);

    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SLOT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = '1;
    localparam logic [SLOT_W-1:0] SLOT_ONE  = 1;
    localparam logic [SLOT_W-1:0] SLOT_WS_R = SLOT_W'(I2S_SLOT_BITS);

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sd_q, sd_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    sample_t               held_q, held_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic                  div_wrap;
    logic                  shift_ev;
    logic                  frame_start;
    logic                  overflow_ev;
    logic [SAMPLE_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .push      (i_SampleReady),
        .push_data (i_Sample),
        .pop       (frame_start),
        .head_data (fifo_head),
        .level     (o_FifoLevel),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        div_wrap    = (div_q == DIV_LAST);
        div_d       = div_wrap ? '0 : div_q + DIV_ONE;
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        // BCLK falling edge is the only point where slot state advances.
        shift_ev    = div_wrap && bclk_q;
        frame_start = shift_ev && (slot_q == SLOT_LAST);
        slot_d      = shift_ev ? slot_q + SLOT_ONE : slot_q;

        held_d      = (frame_start && !fifo_empty) ? sample_t'(fifo_head) : held_q;

        // After 31 shifts the MSB holds the old frame's bit 0, which is exactly
        // what slot 0 must carry, so SD always takes the MSB on a shift event.
        sd_d        = shift_ev ? shift_q[FRAME_BITS-1] : sd_q;
        if (frame_start) begin
            shift_d = {held_d, held_d};
        end else if (shift_ev) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end else begin
            shift_d = shift_q;
        end

        lrclk_d = lrclk_q;
        if (frame_start) begin
            lrclk_d = 1'b0;
        end else if (shift_ev && (slot_d == SLOT_WS_R)) begin
            lrclk_d = 1'b1;
        end

        underrun_d  = frame_start && fifo_empty;
        // A pop in the same cycle frees a slot, so only a non-popping full FIFO drops.
        overflow_ev = i_SampleReady && fifo_full && !frame_start;
        if (overflow_ev) begin
            overflow_d = 1'b1;
        end else if (i_ClearFlags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b1;
            sd_q       <= 1'b0;
            slot_q     <= SLOT_LAST;
            held_q     <= '0;
            shift_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sd_q       <= sd_d;
            slot_q     <= slot_d;
            held_q     <= held_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_BitClock   = bclk_q;
    assign o_LRClock    = lrclk_q;
    assign o_SerialData = sd_q;
    assign o_Underrun   = underrun_q;
    assign o_Overflow   = overflow_q;

`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
    logic [15:0] urun_cnt_q, urun_cnt_d;

    always_comb begin
        if (underrun_d) begin
            urun_cnt_d = (urun_cnt_q == 16'hffff) ? urun_cnt_q : urun_cnt_q + 16'd1;
        end else if (i_ClearFlags) begin
            urun_cnt_d = 16'd0;
        end else begin
            urun_cnt_d = urun_cnt_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            urun_cnt_q <= 16'd0;
        end else begin
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign o_UnderrunCount = urun_cnt_q;
`endif

endmodule

// File: tb/tb_stage_sample_output.sv
// tb/tb_stage_sample_output.sv - directed self-checking bench for stage_sample_output
module tb_stage_sample_output;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [15:0] sample;
    logic        clear;
    logic [2:0]  level;
    logic        ovf;
    logic        und;
    logic        bclk;
    logic        lrclk;
    logic        sd;
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
    logic [15:0] urun_cnt;
`endif

    int cyc;
    int n_total;
    int n_pass;
    int n_fail;

    always #5 clk = ~clk;

    stage_sample_output #(
        .FIFO_DEPTH (4),
        .BCLK_DIV   (2)
    ) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_SampleReady   (ready),
        .i_Sample        (sample),
        .i_ClearFlags    (clear),
        .o_FifoLevel     (level),
        .o_Overflow      (ovf),
        .o_Underrun      (und),
        .o_BitClock      (bclk),
        .o_LRClock       (lrclk),
        .o_SerialData    (sd)
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        ,
        .o_UnderrunCount (urun_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_edge(input int t);
        if (cyc > t) check("schedule", 32'(cyc), 32'(t));
        while (cyc < t) tick();
    endtask

    task automatic push(input int t, input logic [15:0] v);
        wait_edge(t - 1);
        ready  = 1'b1;
        sample = v;
        tick();
        ready  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ovf"},   32'(ovf),   32'd0);
        check({tag, "_und"},   32'(und),   32'd0);
        check({tag, "_bclk"},  32'(bclk),  32'd0);
        check({tag, "_lrclk"}, 32'(lrclk), 32'd1);
        check({tag, "_sd"},    32'(sd),    32'd0);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check({tag, "_cnt"},   32'(urun_cnt), 32'd0);
`endif
    endtask

    // Frame n slot s begins at edge 128*n + 4*(s+1) after reset release.
    task automatic check_frame(input int n, input logic [15:0] w, input logic prev, input logic exp_und);
        int e0;
        logic exp_sd;
        e0 = 128 * n + 4;
        for (int s = 0; s < 32; s++) begin
            wait_edge(e0 + 4 * s);
            exp_sd = (s == 0) ? prev : w[(32 - s) % 16];
            check($sformatf("f%0d_s%0d_sd", n, s),    32'(sd),    32'(exp_sd));
            check($sformatf("f%0d_s%0d_lrclk", n, s), 32'(lrclk), (s < 16) ? 32'd0 : 32'd1);
            check($sformatf("f%0d_s%0d_bclk", n, s),  32'(bclk),  32'd0);
            if (s == 0) begin
                check($sformatf("f%0d_und", n), 32'(und), 32'(exp_und));
                wait_edge(e0 + 1);
                check($sformatf("f%0d_und_end", n), 32'(und), 32'd0);
                wait_edge(e0 + 2);
                check($sformatf("f%0d_bclk_hi", n), 32'(bclk), 32'd1);
            end
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        ready   = 1'b0;
        clear   = 1'b0;
        sample  = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc   = 0;

        wait_edge(1);
        check("e1_bclk", 32'(bclk), 32'd0);
        wait_edge(2);
        check("e2_bclk", 32'(bclk), 32'd1);
        wait_edge(3);
        check("e3_bclk", 32'(bclk), 32'd1);
        check("e3_lrclk", 32'(lrclk), 32'd1);
        check("e3_und", 32'(und), 32'd0);

        // Idle frame: underrun, all-zero data.
        check_frame(0, 16'h0000, 1'b0, 1'b1);

        // Single sample before the frame boundary.
        push(129, 16'hA5F0);
        check("a5f0_level", 32'(level), 32'd1);
        check_frame(1, 16'hA5F0, 1'b0, 1'b0);
        check("a5f0_level_after", 32'(level), 32'd0);
        wait_edge(260);
        check("f2_und", 32'(und), 32'd1);

        // Five back-to-back pushes into a depth-4 FIFO.
        push(262, 16'h1111);
        push(263, 16'h2222);
        push(264, 16'h3333);
        push(265, 16'h4444);
        check("fill_level", 32'(level), 32'd4);
        check("fill_ovf", 32'(ovf), 32'd0);
        push(266, 16'h5555);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_set", 32'(ovf), 32'd1);
        ready  = 1'b1;
        sample = 16'h6666;
        clear  = 1'b1;
        tick();
        ready  = 1'b0;
        check("ovf_beats_clear", 32'(ovf), 32'd1);
        check("ovf_beats_clear_level", 32'(level), 32'd4);
        tick();
        clear  = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        check_frame(3, 16'h1111, 1'b0, 1'b0);
        check("f3_level", 32'(level), 32'd3);
        check_frame(4, 16'h2222, 1'b1, 1'b0);
        check_frame(5, 16'h3333, 1'b0, 1'b0);
        check_frame(6, 16'h4444, 1'b1, 1'b0);
        check("f6_level", 32'(level), 32'd0);

        // Run dry after 8001.
        push(897, 16'h8001);
        check("p8001_level", 32'(level), 32'd1);
        check_frame(7, 16'h8001, 1'b0, 1'b0);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check("cnt_f7", 32'(urun_cnt), 32'd2);
`endif
        check_frame(8, 16'h8001, 1'b1, 1'b1);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check("cnt_f8", 32'(urun_cnt), 32'd3);
`endif

        // Push in the same cycle as an empty-FIFO pop.
        push(1156, 16'h3C5A);
        check("same_cycle_und", 32'(und), 32'd1);
        check("same_cycle_level", 32'(level), 32'd1);
        check_frame(9, 16'h8001, 1'b1, 1'b1);
        check("f9_level", 32'(level), 32'd1);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check("cnt_f9", 32'(urun_cnt), 32'd4);
`endif
        check_frame(10, 16'h3C5A, 1'b1, 1'b0);
        check("f10_level", 32'(level), 32'd0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_ovf", 32'(ovf), 32'd0);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check("cnt_cleared", 32'(urun_cnt), 32'd0);
`endif
        wait_edge(1412);
        check("f11_und", 32'(und), 32'd1);
`ifdef SAMPLE_OUTPUT_UNDERRUN_COUNT_EN
        check("cnt_f11", 32'(urun_cnt), 32'd1);
`endif
        push(1450, 16'h7777);
        check("pre_reset_level", 32'(level), 32'd1);

        // Mid-frame reset at slot 20 with BCLK high.
        wait_edge(1494);
        check("pre_reset_bclk", 32'(bclk), 32'd1);
        check("pre_reset_lrclk", 32'(lrclk), 32'd1);
        check("pre_reset_sd", 32'(sd), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        cyc   = 0;

        push(1, 16'h0F0F);
        check("restart_level", 32'(level), 32'd1);
        check_frame(0, 16'h0F0F, 1'b0, 1'b0);
        check("restart_level_after", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
